// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter that shares one SPI master between N_REQ requesters.
// Optional timeout abort in WAIT is built when SPI_ARB_TIMEOUT_EN is defined.
module spi_txn_arbiter #(
    parameter int N_REQ       = 4,
    parameter int CFG_SETTLE  = 4,
    parameter int TIMEOUT_CYC = 4095
) (
    input  logic                 i_sys_clk,
    input  logic                 i_sys_rst,
    input  logic [N_REQ-1:0]     i_req,
    input  logic [8*N_REQ-1:0]   i_req_data,
    input  logic [32*N_REQ-1:0]  i_req_cfg,
    output logic [N_REQ-1:0]     o_gnt,
    output logic [N_REQ-1:0]     o_ack,
    output logic [7:0]           o_rx_data,
    output logic                 o_err,
    output logic                 o_busy,
    output logic [31:0]          o_data_config,
    output logic [7:0]           o_tx_data,
    output logic                 o_trans_en,
    input  logic                 i_spi_done,
    input  logic [7:0]           i_spi_rx_data
);

    localparam int PW = $clog2(N_REQ);
    localparam int SW = (CFG_SETTLE > 1) ? $clog2(CFG_SETTLE) : 1;

    if (N_REQ < 2 || N_REQ > 8 || CFG_SETTLE < 1 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 4095) begin : g_bad_param
        $error("spi_txn_arbiter: parameter out of range");
    end

    typedef enum logic [2:0] {S_IDLE, S_CFG, S_START, S_WAIT, S_RESP} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   rr_ptr, win_idx, pick_idx;
    logic            pick_vld;
    logic [SW-1:0]   settle_cnt;
    logic            to_hit;

    // First requester at or above rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        int k;
        logic [PW-1:0] kk;
        pick_vld = 1'b0;
        pick_idx = '0;
        k        = 0;
        kk       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            k  = (int'(rr_ptr) + i) % N_REQ;
            kk = PW'(k);
            if (!pick_vld && i_req[kk]) begin
                pick_vld = 1'b1;
                pick_idx = kk;
            end
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    logic [11:0] to_cnt;
    assign to_hit = (to_cnt == 12'(TIMEOUT_CYC - 1));
`else
    assign to_hit = 1'b0;
    assign o_err  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (pick_vld) state_d = S_CFG;
            S_CFG:   if (settle_cnt == SW'(CFG_SETTLE - 1)) state_d = S_START;
            S_START: state_d = S_WAIT;
            S_WAIT:  if (i_spi_done || to_hit) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            state_q       <= S_IDLE;
            rr_ptr        <= '0;
            win_idx       <= '0;
            settle_cnt    <= '0;
            o_gnt         <= '0;
            o_data_config <= '0;
            o_tx_data     <= '0;
            o_rx_data     <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            to_cnt        <= '0;
            o_err         <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: if (pick_vld) begin
                    win_idx       <= pick_idx;
                    o_gnt         <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
                    o_data_config <= i_req_cfg[32*pick_idx +: 32];
                    o_tx_data     <= i_req_data[8*pick_idx +: 8];
                    settle_cnt    <= '0;
                end
                S_CFG: settle_cnt <= settle_cnt + SW'(1);
`ifdef SPI_ARB_TIMEOUT_EN
                S_START: to_cnt <= '0;
                S_WAIT: begin
                    if (i_spi_done) begin
                        o_rx_data <= i_spi_rx_data;
                        o_err     <= 1'b0;
                    end else if (to_hit) begin
                        o_rx_data <= 8'h00;
                        o_err     <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 12'd1;
                    end
                end
`else
                S_WAIT: if (i_spi_done) o_rx_data <= i_spi_rx_data;
`endif
                S_RESP: begin
                    // Config bus deliberately keeps the last word until the next grant.
                    o_gnt  <= '0;
                    rr_ptr <= (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + PW'(1);
`ifdef SPI_ARB_TIMEOUT_EN
                    o_err  <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

    assign o_ack      = o_gnt & {N_REQ{state_q == S_RESP}};
    assign o_trans_en = (state_q == S_START);
    assign o_busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Scoreboard bench for spi_txn_arbiter; timeout case runs when SPI_ARB_TIMEOUT_EN is defined.
module tb_spi_txn_arbiter;

    localparam int N  = 4;
    localparam int CS = 4;
`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 4095;
`endif

    logic            i_sys_clk, i_sys_rst;
    logic [N-1:0]    i_req;
    logic [8*N-1:0]  i_req_data;
    logic [32*N-1:0] i_req_cfg;
    logic [N-1:0]    o_gnt, o_ack;
    logic [7:0]      o_rx_data, o_tx_data, i_spi_rx_data;
    logic            o_err, o_busy, o_trans_en, i_spi_done;
    logic [31:0]     o_data_config;

    spi_txn_arbiter #(.N_REQ(N), .CFG_SETTLE(CS), .TIMEOUT_CYC(TO)) dut (
        .i_sys_clk(i_sys_clk), .i_sys_rst(i_sys_rst), .i_req(i_req),
        .i_req_data(i_req_data), .i_req_cfg(i_req_cfg), .o_gnt(o_gnt),
        .o_ack(o_ack), .o_rx_data(o_rx_data), .o_err(o_err), .o_busy(o_busy),
        .o_data_config(o_data_config), .o_tx_data(o_tx_data),
        .o_trans_en(o_trans_en), .i_spi_done(i_spi_done),
        .i_spi_rx_data(i_spi_rx_data)
    );

    typedef struct packed {
        logic [N-1:0] ack;
        logic [7:0]   rx;
        logic         err;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] cfg_arr[N];
    logic [7:0]  dat_arr[N];

    initial i_sys_clk = 1'b0;
    always #5 i_sys_clk = ~i_sys_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_sys_clk);
        #1;
    endtask

    task automatic load(input int k, input logic [31:0] cfg, input logic [7:0] dat);
        cfg_arr[k] = cfg;
        dat_arr[k] = dat;
        i_req_cfg[32*k +: 32] = cfg;
        i_req_data[8*k +: 8]  = dat;
    endtask

    // Every ack must match the oldest pushed expectation.
    always @(negedge i_sys_clk) begin
        if (!i_sys_rst && |o_ack) begin
            exp_t e;
            if (sbq.size() == 0) chk("ack_unexpected", 64'(o_ack), 64'd0);
            else begin
                e = sbq.pop_front();
                chk("sb_ack", 64'(o_ack), 64'(e.ack));
                chk("sb_rx", 64'(o_rx_data), 64'(e.rx));
                chk("sb_err", 64'(o_err), 64'(e.err));
            end
        end
    end

    task automatic run_one(input int idx, input logic [7:0] rx, input int dly,
                           input bit noise, input bit drop, input bit keep);
        int n;
        logic [31:0] ecfg;
        logic [N-1:0] oh;
        exp_t e;
        oh   = N'(1) << idx;
        ecfg = cfg_arr[idx];
        n = 0;
        do begin tick(); n++; end while (o_gnt == '0 && n < 8);
        chk("gnt_lat", 64'(n), 64'd1);
        chk("gnt", 64'(o_gnt), 64'(oh));
        chk("cfg", 64'(o_data_config), 64'(ecfg));
        chk("tx", 64'(o_tx_data), 64'(dat_arr[idx]));
        chk("busy", 64'(o_busy), 64'd1);
        i_req_cfg[32*idx +: 32] = ~ecfg;
        i_req_data[8*idx +: 8]  = ~dat_arr[idx];
        if (drop) i_req[idx] = 1'b0;
        n = 0;
        if (noise) begin
            i_spi_done = 1'b1; i_spi_rx_data = 8'hEE;
            tick(); i_spi_done = 1'b0; n++;
        end
        while (!o_trans_en && n < 40) begin tick(); n++; end
        chk("trans_en_lat", 64'(n), 64'(CS));
        if (noise) i_spi_done = 1'b1;
        tick(); i_spi_done = 1'b0;
        chk("trans_en_pulse", 64'(o_trans_en), 64'd0);
        repeat (dly) tick();
        chk("no_early_ack", 64'(o_ack), 64'd0);
        i_spi_done = 1'b1; i_spi_rx_data = rx;
        e.ack = oh; e.rx = rx; e.err = 1'b0;
        sbq.push_back(e);
        tick(); i_spi_done = 1'b0;
        chk("ack", 64'(o_ack), 64'(oh));
        chk("ack_rx", 64'(o_rx_data), 64'(rx));
        chk("ack_gnt", 64'(o_gnt), 64'(oh));
        chk("cfg_frozen", 64'(o_data_config), 64'(ecfg));
        chk("tx_frozen", 64'(o_tx_data), 64'(dat_arr[idx]));
        i_req_cfg[32*idx +: 32] = ecfg;
        i_req_data[8*idx +: 8]  = dat_arr[idx];
        if (!keep) i_req[idx] = 1'b0;
        tick();
        chk("ack_pulse", 64'(o_ack), 64'd0);
        chk("gnt_clr", 64'(o_gnt), 64'd0);
        chk("idle", 64'(o_busy), 64'd0);
        chk("cfg_hold", 64'(o_data_config), 64'(ecfg));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int n;
        i_sys_rst = 1'b1; i_req = '0; i_spi_done = 1'b0; i_spi_rx_data = '0;
        i_req_cfg = '0; i_req_data = '0;
        for (int k = 0; k < N; k++) load(k, 32'h1000_0000 * (k + 1) + 32'h0000_0ABC, 8'h20 + 8'(k));
        tick(); tick();
        chk("rst_gnt", 64'(o_gnt), 64'd0);
        chk("rst_ack", 64'(o_ack), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_ten", 64'(o_trans_en), 64'd0);
        chk("rst_cfg", 64'(o_data_config), 64'd0);
        chk("rst_tx", 64'(o_tx_data), 64'd0);
        chk("rst_rx", 64'(o_rx_data), 64'd0);
        chk("rst_err", 64'(o_err), 64'd0);
        i_sys_rst = 1'b0;

        // contention: all four held, expect 0,1,2,3,0
        i_req = '1;
        for (int i = 0; i < 5; i++) run_one(i % N, 8'h10 + 8'(i), 3, 1'b0, 1'b0, 1'b1);
        i_req = '0;
        tick();

        load(2, 32'h5C00_1011, 8'hA5);
        i_req = 4'b0100;
        run_one(2, 8'h3C, 20, 1'b0, 1'b0, 1'b0);

        // stray done in CFG and START must be ignored
        i_req = 4'b1000;
        run_one(3, 8'h5A, 2, 1'b1, 1'b0, 1'b0);

        i_req = 4'b0010;
        run_one(1, 8'h77, 4, 1'b0, 1'b1, 1'b0);

        // rr_ptr is now 2: requester 2 beats 0, then 0 wins by wrapping
        i_req = 4'b0101;
        run_one(2, 8'hC3, 1, 1'b0, 1'b0, 1'b0);
        run_one(0, 8'h81, 1, 1'b0, 1'b0, 1'b0);

`ifdef SPI_ARB_TIMEOUT_EN
        begin
            exp_t e;
            i_req = 4'b0001;
            n = 0;
            do begin tick(); n++; end while (o_gnt == '0 && n < 8);
            chk("to_gnt", 64'(o_gnt), 64'd1);
            n = 0;
            while (!o_trans_en && n < 40) begin tick(); n++; end
            e.ack = 4'b0001; e.rx = 8'h00; e.err = 1'b1;
            sbq.push_back(e);
            tick();
            n = 0;
            while (o_ack == '0 && n < 40) begin tick(); n++; end
            chk("to_wait_cycles", 64'(n), 64'd16);
            chk("to_err", 64'(o_err), 64'd1);
            chk("to_rx", 64'(o_rx_data), 64'd0);
            i_req = '0;
            tick();
            chk("to_err_clr", 64'(o_err), 64'd0);
        end
`endif

        // reset while waiting for done
        i_req = 4'b1000;
        n = 0;
        do begin tick(); n++; end while (o_gnt == '0 && n < 8);
        chk("rw_gnt", 64'(o_gnt), 64'b1000);
        n = 0;
        while (!o_trans_en && n < 40) begin tick(); n++; end
        repeat (4) tick();
        i_req = '0; i_sys_rst = 1'b1;
        tick();
        i_sys_rst = 1'b0;
        chk("rw_gnt0", 64'(o_gnt), 64'd0);
        chk("rw_ack0", 64'(o_ack), 64'd0);
        chk("rw_busy0", 64'(o_busy), 64'd0);
        chk("rw_ten0", 64'(o_trans_en), 64'd0);
        chk("rw_cfg0", 64'(o_data_config), 64'd0);
        chk("rw_tx0", 64'(o_tx_data), 64'd0);
        chk("rw_rx0", 64'(o_rx_data), 64'd0);
        chk("rw_err0", 64'(o_err), 64'd0);
        i_spi_done = 1'b1; i_spi_rx_data = 8'h99;
        tick(); i_spi_done = 1'b0;
        tick();
        chk("rw_no_ack", 64'(o_ack), 64'd0);
        chk("rw_idle", 64'(o_busy), 64'd0);
        repeat (3) tick();

        chk("sb_empty", 64'(sbq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_txn_arbiter.md
Name: spi_txn_arbiter

Overview:
Shares one spi_module master instance between N on-chip requesters. The block arbitrates round-robin and loads the winner's 32-bit config word onto the SPI config bus. It holds that word stable for a settle window, pulses the transfer enable, waits for byte completion, then returns the received byte with a one-cycle ack. It sits between the requester fabric and the SPI master's i_data_config/i_trans_en/i_data/o_data pins.

Parameters:
N_REQ, 4, number of requesters (2..8)
CFG_SETTLE, 4, cycles config is held stable before o_trans_en (>=1)
TIMEOUT_CYC, 4095, max WAIT cycles before abort (used only with SPI_ARB_TIMEOUT_EN)

Ports:
i_sys_clk  in  1  system clock, all logic on rising edge
i_sys_rst  in  1  reset, synchronous, active-high
i_req  in  N_REQ  per-requester request level, held until matching ack
i_req_data  in  8*N_REQ  TX byte, requester k at [8k+7:8k]
i_req_cfg  in  32*N_REQ  SPI config word, requester k at [32k+31:32k]
o_gnt  out  N_REQ  one-hot grant, high for the whole transaction
o_ack  out  N_REQ  one-cycle completion pulse to the granted requester
o_rx_data  out  8  received byte, valid while any o_ack bit is high
o_err  out  1  high with o_ack when the transfer timed out
o_busy  out  1  high in every state except IDLE
o_data_config  out  32  to SPI master i_data_config
o_tx_data  out  8  to SPI master i_data
o_trans_en  out  1  to SPI master i_trans_en, one-cycle pulse
i_spi_done  in  1  completion strobe from SPI side (SPIF rising, synchronised), one cycle
i_spi_rx_data  in  8  SPI master o_data, sampled when i_spi_done is high

Behaviour:
- Reset (i_sys_rst=1 at an edge): state=IDLE, rr_ptr=0, all outputs 0. o_data_config is 0. Reset mid-transaction aborts at once; no ack is issued; o_trans_en drops the same edge.
- FSM states: IDLE, CFG, START, WAIT, RESP.
- IDLE: if i_req != 0, pick the first set bit at or above rr_ptr, wrapping modulo N_REQ.
  - Next cycle: state=CFG, o_gnt=onehot(winner), o_data_config/o_tx_data latched from the winner's slices, settle counter=0.
- Captured config/data stay frozen for the whole transaction. Requester input changes are ignored until the next grant.
- CFG: count CFG_SETTLE cycles, then go to START.
- START: o_trans_en=1 for exactly one cycle, then go to WAIT.
- WAIT: on i_spi_done=1, capture i_spi_rx_data into o_rx_data and go to RESP.
  - i_spi_done outside WAIT is ignored.
  - i_spi_done in the same cycle as START is ignored.
- RESP: o_ack[winner]=1 for one cycle, o_gnt still held, o_err per timeout status. rr_ptr=(winner+1) mod N_REQ. Next state IDLE, with o_gnt and o_err cleared on entry.
- Latency: req seen in IDLE at cycle t gives gnt at t+1 and o_trans_en at t+1+CFG_SETTLE. Ack comes one cycle after done.
  - Min back-to-back spacing: RESP, then IDLE, then CFG, so the next grant comes 2 cycles after the ack.
- A requester dropping i_req mid-transaction does not abort it; the ack is still pulsed.
- Multiple requests at once: only rr_ptr order matters; no starvation, and each requester waits at most N_REQ-1 transactions.
- Requests set with rr_ptr pointing at an idle requester: search wraps upward.
- o_data_config keeps its last value after a transaction (no glitch to 0). The SPI master sees a change only at the next grant.

Optional Feature:
Macro SPI_ARB_TIMEOUT_EN.
- Defined: a 12-bit counter clears on WAIT entry and increments each WAIT cycle. Reaching TIMEOUT_CYC with no done gives RESP with o_err=1 and o_rx_data=8'h00.
- Not defined: no counter, o_err tied 0, and WAIT waits indefinitely for i_spi_done.

Test Plan:
- Single request: i_req=4'b0100, cfg=32'h5C00_1011, data=8'hA5; done after 20 cycles with rx=8'h3C. Checks:
  - gnt=4'b0100 one cycle after req.
  - o_data_config=32'h5C00_1011 and o_tx_data=8'hA5.
  - trans_en pulse CFG_SETTLE cycles later.
  - ack[2] with o_rx_data=8'h3C one cycle after done.
- Contention: i_req=4'b1111 held, every transfer completed. Grant order must be 0,1,2,3,0 with one ack per grant and no overlap.
- Simultaneous-event corner: done asserted during CFG and in the START cycle, then again in WAIT. Only the WAIT done is accepted and exactly one ack results.
- Request drop: requester 1 drops i_req after grant. The transaction completes, ack[1] still pulses, and rr_ptr advances to 2.
- Reset mid-WAIT: assert i_sys_rst for one cycle. The next cycle has all outputs 0, state IDLE, and a later done produces no ack.
- With SPI_ARB_TIMEOUT_EN and TIMEOUT_CYC=16: never assert done. ack arrives with o_err=1 and o_rx_data=8'h00 after 16 WAIT cycles.
